// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register and operand select for the 32-bit ALU.
// Forwards EX/MEM and MEM/WB results and bubbles on load-use hazards.
module id_ex_operand_stage #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              id_i_valid,
    output logic              id_o_ready,
    input  logic [3:0]        id_i_alu_op,
    input  logic [AWIDTH-1:0] id_i_rs_addr,
    input  logic [AWIDTH-1:0] id_i_rt_addr,
    input  logic [AWIDTH-1:0] id_i_rd_addr,
    input  logic [DWIDTH-1:0] id_i_rs_data,
    input  logic [DWIDTH-1:0] id_i_rt_data,
    input  logic [DWIDTH-1:0] id_i_imm,
    input  logic [4:0]        id_i_shamt,
    input  logic              id_i_use_imm,
    input  logic              id_i_use_shamt,
    input  logic              id_i_rt_used,
    input  logic              id_i_reg_write,
    input  logic              id_i_mem_read,
    input  logic              mem_i_reg_write,
    input  logic [AWIDTH-1:0] mem_i_rd_addr,
    input  logic [DWIDTH-1:0] mem_i_data,
    input  logic              wb_i_reg_write,
    input  logic [AWIDTH-1:0] wb_i_rd_addr,
    input  logic [DWIDTH-1:0] wb_i_data,
    input  logic              ex_i_ready,
    output logic              ex_o_valid,
    output logic [DWIDTH-1:0] ex_o_alu_rs,
    output logic [DWIDTH-1:0] ex_o_alu_rt,
    output logic [3:0]        ex_o_alu_funct,
    output logic [AWIDTH-1:0] ex_o_rd_addr,
    output logic              ex_o_reg_write,
    output logic              ex_o_mem_read,
    output logic [DWIDTH-1:0] ex_o_store_data,
    output logic              o_load_use_stall
);

    logic              r_valid;
    logic [3:0]        r_alu_op;
    logic [AWIDTH-1:0] r_rs_addr;
    logic [AWIDTH-1:0] r_rt_addr;
    logic [AWIDTH-1:0] r_rd_addr;
    logic [DWIDTH-1:0] r_rs_data;
    logic [DWIDTH-1:0] r_rt_data;
    logic [DWIDTH-1:0] r_imm;
    logic [4:0]        r_shamt;
    logic              r_use_imm;
    logic              r_use_shamt;
    logic              r_reg_write;
    logic              r_mem_read;

    logic              w_advance;
    logic              w_hazard;
    logic              w_stall;
    logic [DWIDTH-1:0] w_fwd_rs;
    logic [DWIDTH-1:0] w_fwd_rt;

    // Youngest producer wins; register 0 is hardwired and never forwarded.
    function automatic logic [DWIDTH-1:0] fwd_sel(
        input logic [AWIDTH-1:0] src,
        input logic [DWIDTH-1:0] rf_data,
        input logic              m_we,
        input logic [AWIDTH-1:0] m_rd,
        input logic [DWIDTH-1:0] m_data,
        input logic              w_we,
        input logic [AWIDTH-1:0] w_rd,
        input logic [DWIDTH-1:0] w_data
    );
        if (m_we && (m_rd == src) && (src != {AWIDTH{1'b0}})) begin
            return m_data;
        end else if (w_we && (w_rd == src) && (src != {AWIDTH{1'b0}})) begin
            return w_data;
        end else begin
            return rf_data;
        end
    endfunction

    // Handshake, load-use detection, forwarding and operand select.
    always_comb begin
        w_advance = !r_valid || ex_i_ready;
        w_hazard  = r_valid && r_mem_read && r_reg_write &&
                    (r_rd_addr != {AWIDTH{1'b0}}) &&
                    (((r_rd_addr == id_i_rs_addr) && !id_i_use_shamt) ||
                     ((r_rd_addr == id_i_rt_addr) && id_i_rt_used));
        w_stall   = w_hazard && id_i_valid;
        w_fwd_rs  = fwd_sel(r_rs_addr, r_rs_data, mem_i_reg_write, mem_i_rd_addr,
                            mem_i_data, wb_i_reg_write, wb_i_rd_addr, wb_i_data);
        w_fwd_rt  = fwd_sel(r_rt_addr, r_rt_data, mem_i_reg_write, mem_i_rd_addr,
                            mem_i_data, wb_i_reg_write, wb_i_rd_addr, wb_i_data);

        o_load_use_stall = w_stall;
        id_o_ready       = w_advance && !w_stall;
        ex_o_valid       = r_valid;
        ex_o_rd_addr     = r_rd_addr;
        ex_o_store_data  = w_fwd_rt;
        ex_o_alu_funct   = r_valid ? r_alu_op : 4'd15;
        ex_o_reg_write   = r_valid && r_reg_write;
        ex_o_mem_read    = r_valid && r_mem_read;
        if (r_use_shamt) begin
            ex_o_alu_rs = w_fwd_rt;
            ex_o_alu_rt = {{(DWIDTH-5){1'b0}}, r_shamt};
        end else if (r_use_imm) begin
            ex_o_alu_rs = w_fwd_rs;
            ex_o_alu_rt = r_imm;
        end else begin
            ex_o_alu_rs = w_fwd_rs;
            ex_o_alu_rt = w_fwd_rt;
        end
    end

    // Pipeline register: reset, flush, bubble, capture or hold.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid     <= 1'b0;
            r_alu_op    <= 4'd0;
            r_rs_addr   <= {AWIDTH{1'b0}};
            r_rt_addr   <= {AWIDTH{1'b0}};
            r_rd_addr   <= {AWIDTH{1'b0}};
            r_rs_data   <= {DWIDTH{1'b0}};
            r_rt_data   <= {DWIDTH{1'b0}};
            r_imm       <= {DWIDTH{1'b0}};
            r_shamt     <= 5'd0;
            r_use_imm   <= 1'b0;
            r_use_shamt <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
        end else if (i_flush) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
        end else if (w_advance && w_stall) begin
            r_valid     <= 1'b0;
        end else if (w_advance) begin
            r_valid     <= id_i_valid;
            r_alu_op    <= id_i_alu_op;
            r_rs_addr   <= id_i_rs_addr;
            r_rt_addr   <= id_i_rt_addr;
            r_rd_addr   <= id_i_rd_addr;
            r_rs_data   <= id_i_rs_data;
            r_rt_data   <= id_i_rt_data;
            r_imm       <= id_i_imm;
            r_shamt     <= id_i_shamt;
            r_use_imm   <= id_i_use_imm;
            r_use_shamt <= id_i_use_shamt;
            r_reg_write <= id_i_reg_write;
            r_mem_read  <= id_i_mem_read;
        end else begin
            r_valid     <= r_valid;
        end
    end

endmodule
